// File: rtl/mini_cpu_core_param.sv
// mini_cpu_core_param: button-driven mini CPU with a generic register file,
// a shift-add multiplier and a busy/valid handshake toward the LCD driver.
// Optional build macro MINI_CPU_SAT_EN: clamp overflowing results to the
// signed max/min instead of wrapping.
module mini_cpu_core_param #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4,
    parameter int unsigned FW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ligar,
    input  logic          enviar,
    input  logic [2:0]    opcode,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [FW-1:0] addr3_imm,
    output logic [DW-1:0] result,
    output logic [2:0]    result_op,
    output logic          result_valid,
    output logic          overflow,
    output logic          busy,
    output logic          powered
);
    localparam int unsigned NREG = 2**AW;
    localparam int unsigned PW   = 2*DW;
    localparam int unsigned CW   = $clog2(DW) + 1;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

`ifdef MINI_CPU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_OFF, S_FETCH, S_DECODE, S_EXEC, S_STORE} state_t;

    state_t          state;
    logic [DW-1:0]   regs [NREG];
    logic [2:0]      lig_sync, env_sync;     // [0],[1] synchroniser, [2] previous value
    logic            lig_rel, env_rel;
    logic [2:0]      op_q;
    logic [AW-1:0]   a1_q, a2_q;
    logic [FW-1:0]   a3imm_q;
    logic [DW-1:0]   opa, opb;
    logic [PW-1:0]   mcand, acc;
    logic [DW-1:0]   mplier;
    logic            mneg;
    logic [CW-1:0]   cnt;

    logic [AW-1:0]   addr3;
    logic [DW-1:0]   imm_ext, imm, rd_a, rd_b, rd_d, abs_a, abs_b;
    logic [DW-1:0]   sum, diff, raw, wr_val;
    logic [PW-1:0]   acc_nxt, prod;
    logic            add_ovf, sub_ovf, mul_ovf, ovf_c, neg_c, wr_en_c;

    // Button synchronisers; presets represent released buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lig_sync <= '1;
            env_sync <= '1;
        end else begin
            lig_sync <= {lig_sync[1:0], ligar};
            env_sync <= {env_sync[1:0], enviar};
        end
    end

    assign lig_rel = lig_sync[1] & ~lig_sync[2];
    assign env_rel = env_sync[1] & ~env_sync[2];

    // Field decode of the latched instruction and register reads
    assign addr3   = a3imm_q[FW-1 -: AW];
    assign imm_ext = DW'(a3imm_q[FW-2:0]);
    assign imm     = a3imm_q[FW-1] ? -imm_ext : imm_ext;
    assign rd_a    = regs[a2_q];
    assign rd_b    = regs[addr3];
    assign rd_d    = regs[a1_q];
    assign abs_a   = rd_a[DW-1] ? -rd_a : rd_a;
    assign abs_b   = rd_b[DW-1] ? -rd_b : rd_b;

    // Arithmetic datapath and signed overflow detection
    assign sum     = opa + opb;
    assign diff    = opa - opb;
    assign add_ovf = (opa[DW-1] == opb[DW-1]) && (sum[DW-1] != opa[DW-1]);
    assign sub_ovf = (opa[DW-1] != opb[DW-1]) && (diff[DW-1] != opa[DW-1]);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign prod    = mneg ? -acc_nxt : acc_nxt;
    assign mul_ovf = prod[PW-1:DW] != {DW{prod[DW-1]}};

    // Result selection per opcode; neg_c is the true sign when overflowing
    always_comb begin
        raw     = '0;
        ovf_c   = 1'b0;
        neg_c   = 1'b0;
        wr_en_c = 1'b1;
        case (op_q)
            OP_LOAD:          raw = opb;
            OP_ADD, OP_ADDI:  begin raw = sum;  ovf_c = add_ovf; neg_c = opa[DW-1]; end
            OP_SUB, OP_SUBI:  begin raw = diff; ovf_c = sub_ovf; neg_c = opa[DW-1]; end
            OP_MUL:           begin raw = prod[DW-1:0]; ovf_c = mul_ovf; neg_c = mneg; end
            OP_CLEAR:         raw = '0;
            default:          begin raw = opa; wr_en_c = 1'b0; end
        endcase
        wr_val = (SAT_EN && ovf_c) ? (neg_c ? SMIN : SMAX) : raw;
    end

    // Control FSM, register file and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
            result       <= '0;
            result_op    <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            powered      <= 1'b1;
            op_q         <= '0;
            a1_q         <= '0;
            a2_q         <= '0;
            a3imm_q      <= '0;
            opa          <= '0;
            opb          <= '0;
            mcand        <= '0;
            acc          <= '0;
            mplier       <= '0;
            mneg         <= 1'b0;
            cnt          <= '0;
        end else begin
            result_valid <= 1'b0;
            if (state != S_OFF && lig_rel) begin
                state     <= S_OFF;
                for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
                result    <= '0;
                result_op <= '0;
                overflow  <= 1'b0;
                busy      <= 1'b0;
                powered   <= 1'b0;
            end else begin
                case (state)
                    S_OFF: begin
                        if (lig_rel) begin
                            state   <= S_FETCH;
                            powered <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (env_rel) begin
                            op_q    <= opcode;
                            a1_q    <= addr1;
                            a2_q    <= addr2;
                            a3imm_q <= addr3_imm;
                            busy    <= 1'b1;
                            state   <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        opa    <= (op_q == OP_DISPLAY) ? rd_d : rd_a;
                        opb    <= (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_MUL) ? rd_b : imm;
                        mcand  <= PW'(abs_a);
                        mplier <= abs_b;
                        mneg   <= rd_a[DW-1] ^ rd_b[DW-1];
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_EXEC;
                    end
                    S_EXEC: begin
                        if (op_q == OP_MUL && cnt != CW'(DW-1)) begin
                            acc    <= acc_nxt;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                            cnt    <= cnt + CW'(1);
                        end else begin
                            if (op_q == OP_CLEAR) begin
                                for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
                            end else if (wr_en_c) begin
                                regs[a1_q] <= wr_val;
                            end
                            result       <= wr_val;
                            result_op    <= op_q;
                            result_valid <= 1'b1;
                            if (op_q != OP_DISPLAY) overflow <= ovf_c;
                            state        <= S_STORE;
                        end
                    end
                    S_STORE: begin
                        busy  <= 1'b0;
                        state <= S_FETCH;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_FETCH;
                    end
                endcase
            end
        end
    end

endmodule
